// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank: FSM encoding and
// the syscall codes the block reacts to.
package perf_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } perf_state_t;

    localparam logic [31:0] SYS_HALT = 32'd10;
    localparam logic [31:0] SYS_SHOW = 32'd34;

endpackage

// File: rtl/perf_counter_bank_if.sv
// Read port of the counter bank: request (enable, live/shadow select, index)
// and the registered result with its valid flag.
interface perf_counter_bank_if #(
    parameter int WIDTH = 32,
    parameter int IW    = 2
);
    logic             rd_en;
    logic             rd_shadow;
    logic [IW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;

    modport master (
        output rd_en, rd_shadow, rd_idx,
        input  rd_data, rd_valid
    );

    modport slave (
        input  rd_en, rd_shadow, rd_idx,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/perf_counter.sv
// One counter channel: increment with wrap or saturate, sticky overflow,
// synchronous clear and a shadow copy loaded on snap.
module perf_counter #(
    parameter int WIDTH    = 32,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             snap,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] shadow,
    output logic             ovf
);

    // Shadow sees the pre-edge count, so snap together with clr keeps the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            shadow <= '0;
            ovf    <= 1'b0;
        end else begin
            if (snap) begin
                shadow <= count;
            end
            if (clr) begin
                count <= '0;
                ovf   <= 1'b0;
            end else if (inc) begin
                if (count == '1) begin
                    ovf   <= 1'b1;
                    count <= (SATURATE != 0) ? count : '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of a cycle counter plus NUM_EVT event counters with a halt FSM driven by
// writeback syscalls, a display register and a one-cycle-latency read port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_EVT  = 3,
    parameter int SATURATE = 0,
    parameter int IW       = $clog2(NUM_EVT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               syscall_t,
    input  logic [31:0]        a0,
    input  logic [WIDTH-1:0]   a1,
    input  logic               clr,
    input  logic               snap,
    perf_counter_bank_if.slave rd_bus,
    output logic [NUM_EVT:0]   ovf,
    output logic [WIDTH-1:0]   disp_out,
    output logic               disp_valid,
    output logic               halt
);

    perf_state_t      state;
    perf_state_t      next_state;
    logic             halt_accept;
    logic             count_en;
    logic             show_req;
    logic [NUM_EVT:0] chan_inc;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] live_val   [NUM_EVT+1];
    logic [WIDTH-1:0] shadow_val [NUM_EVT+1];

    // The accept cycle itself still counts; counting stops once HALTED is entered.
    assign count_en = en && (state == RUN);
    assign chan_inc = {evt, 1'b1} & {(NUM_EVT + 1){count_en}};
    assign show_req = en && syscall_t && (a0 == SYS_SHOW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        halt_accept = 1'b0;
        halt        = 1'b0;
        if ((state == RUN) && en && syscall_t && (a0 == SYS_HALT)) begin
            halt_accept = 1'b1;
        end
        if (clr) begin
            next_state = RUN;
        end else if (halt_accept) begin
            next_state = HALTED;
        end
        halt = halt_accept || (state == HALTED);
    end

    genvar g;
    generate
        for (g = 0; g <= NUM_EVT; g++) begin : g_chan
            perf_counter #(
                .WIDTH    (WIDTH),
                .SATURATE (SATURATE)
            ) u_counter (
                .clk    (clk),
                .rst    (rst),
                .inc    (chan_inc[g]),
                .clr    (clr),
                .snap   (snap),
                .count  (live_val[g]),
                .shadow (shadow_val[g]),
                .ovf    (ovf[g])
            );
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        if (int'(rd_bus.rd_idx) <= NUM_EVT) begin
            rd_word = rd_bus.rd_shadow ? shadow_val[rd_bus.rd_idx] : live_val[rd_bus.rd_idx];
        end
    end

    // Read result is registered from pre-edge values and held while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_bus.rd_data  <= '0;
            rd_bus.rd_valid <= 1'b0;
        end else begin
            rd_bus.rd_valid <= rd_bus.rd_en;
            if (rd_bus.rd_en) begin
                rd_bus.rd_data <= rd_word;
            end
        end
    end

    // Display updates are honoured in both RUN and HALTED.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_out   <= '0;
            disp_valid <= 1'b0;
        end else begin
            disp_valid <= show_req;
            if (show_req) begin
                disp_out <= a1;
            end
        end
    end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning counter and data bit width (min 4).
REQ-002 The block SHALL have parameter NUM_EVT, default 3, meaning number of event channels in addition to the cycle channel.
REQ-003 The block SHALL have parameter SATURATE, default 0, meaning 0 = counters wrap, 1 = counters hold at all-ones.
REQ-004 The block SHALL have parameter IW, default $clog2(NUM_EVT+1), meaning read-index width.
REQ-005 clk  in  1  the block's one clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  count enable (pipeline not stalled).
REQ-008 evt  in  NUM_EVT  per-channel event strobes; channel k+1 counts evt[k].
REQ-009 syscall_t  in  1  syscall in writeback.
REQ-010 a0  in  32  syscall code register value.
REQ-011 a1  in  WIDTH  syscall argument.
REQ-012 clr  in  1  synchronous clear of counters, overflow flags and HALTED state.
REQ-013 snap  in  1  copy all live counters into shadow registers.
REQ-014 rd_en, rd_shadow, rd_idx  in  1, 1, IW  read request, live/shadow select, channel index.
REQ-015 rd_data, rd_valid  out  WIDTH, 1  registered read result and its valid flag.
REQ-016 ovf  out  NUM_EVT+1  sticky per-channel overflow flags.
REQ-017 disp_out, disp_valid  out  WIDTH, 1  display register and its one-cycle update pulse.
REQ-018 halt  out  1  high in the accept cycle and throughout HALTED.

Function
REQ-019 Channel 0 SHALL increment on every cycle with en=1 while the block is in state RUN; channel k+1 SHALL increment when en=1, evt[k]=1 and the state is RUN.
REQ-020 The states SHALL be RUN and HALTED; RUN SHALL go to HALTED on the edge where en=1, syscall_t=1 and a0=10; HALTED SHALL go to RUN only on clr=1 or reset.
REQ-021 The halt-accept cycle itself SHALL be counted; counting SHALL stop from the next cycle.
REQ-022 halt SHALL be combinational, asserted in the accept cycle, and SHALL stay high while the state is HALTED.
REQ-023 On increment from all-ones: with SATURATE=0 the counter SHALL wrap to 0; with SATURATE=1 it SHALL hold all-ones; in both cases ovf[ch] SHALL be set.
REQ-024 An ovf bit, once set, SHALL stay set until clr or reset.
REQ-025 On clr, all counters and ovf bits SHALL become 0 and the state SHALL become RUN; clr SHALL win over any simultaneous increment.
REQ-026 The shadow registers SHALL be left unchanged by clr.
REQ-027 On snap, every shadow register SHALL load its live counter's pre-edge value.
REQ-028 On snap together with clr, the shadow SHALL capture the pre-clear values.
REQ-029 A read SHALL have a latency of 1 cycle: rd_en at edge N gives rd_data/rd_valid at N+1; rd_valid SHALL equal the previous cycle's rd_en.
REQ-030 rd_data SHALL hold its last value when rd_en=0.
REQ-031 An rd_idx > NUM_EVT SHALL return 0 with rd_valid=1.
REQ-032 Reads SHALL return pre-edge register values (read-before-update).
REQ-033 When en=1, syscall_t=1 and a0=34, disp_out SHALL load a1 and disp_valid SHALL pulse for one cycle; this SHALL occur in either state.
REQ-034 Other a0 codes SHALL have no effect on the block.

Reset
REQ-035 On rst=0, asynchronously: all counters, shadows, ovf, rd_data, rd_valid, disp_out and disp_valid SHALL become 0 and the state SHALL become RUN.
REQ-036 Reset asserted mid-operation SHALL abandon any read in flight; rd_valid SHALL be 0 on the first cycle after release.
REQ-037 Counting SHALL resume on the first edge after reset release.

Structure
REQ-038 A shared package perf_pkg SHALL hold the state encoding (RUN, HALTED) and the syscall code constants SYS_HALT=10 and SYS_SHOW=34.
REQ-039 One sub-module, perf_counter, SHALL implement a single channel (increment, clear, wrap/saturate, sticky overflow, shadow); it SHALL be instantiated NUM_EVT+1 times by generate.
REQ-040 The read mux, FSM and display register SHALL live in the top level.

Verification
REQ-041 Reset, then 5 cycles with en=1 and evt=3'b101, then read live idx 0..3 SHALL return 5, 5, 0, 5 with rd_valid one cycle after each rd_en.
REQ-042 syscall_t=1, a0=10 at cycle 7 SHALL assert halt that cycle; channel 0 SHALL read 7 and stay 7 for 10 further cycles; clr SHALL drop halt and the next cycle SHALL count 1.
REQ-043 With WIDTH=4, SATURATE=0, 17 en cycles SHALL give channel 0 = 1 and ovf[0]=1; with SATURATE=1 the same stimulus SHALL give 15 and ovf[0]=1.
REQ-044 Counters at 9 with snap and clr in the same cycle SHALL read live 0 and shadow 9.
REQ-045 a0=34, a1=0xDEADBEEF, syscall_t=1 SHALL give disp_out=0xDEADBEEF with a single-cycle disp_valid; the same in HALTED SHALL also update disp_out.
REQ-046 rst pulsed low mid-count with rd_en=1 SHALL immediately zero all outputs, and rd_valid SHALL be 0 after release.
